// File: rtl/adc_sample_avg.sv
// Per-channel windowed averager for ADC results with a thermometer LED bar.
// Define PEAK_HOLD_EN to build the peak-hold register driven by peak_clr.
module adc_sample_avg #(
    parameter int DATA_W       = 12,
    parameter int CH_W         = 3,
    parameter int LOG2_MAX_AVG = 4,
    parameter int LED_W        = 10
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [CH_W-1:0]   sample_ch,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [2:0]        avg_len,
    input  logic              peak_clr,
    output logic [DATA_W-1:0] avg_data,
    output logic              avg_valid,
    output logic [LED_W-1:0]  ledr_bar,
    output logic [DATA_W-1:0] peak_data
);

    localparam int ACC_W = DATA_W + LOG2_MAX_AVG;
    localparam int CNT_W = LOG2_MAX_AVG + 1;
    localparam int MUL_W = DATA_W + 4;
    localparam logic [2:0] MAX_LEN = 3'(LOG2_MAX_AVG);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] avg_data_q, avg_data_d;
    logic [LED_W-1:0]  ledr_q, ledr_d;
    logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
    logic [2:0]        avg_len_q, avg_len_d;

    logic [2:0]        eff_len;
    logic [CNT_W-1:0]  win_n;
    logic              cfg_change;
    logic              accept;
    logic              load_avg;
    logic [ACC_W-1:0]  sample_ext;
    logic [MUL_W-1:0]  lit_prod;
    logic [MUL_W-1:0]  lit;

    // Any accepted sample implies the config matches last cycle, so the
    // registered avg_len is the window length in every state.
    assign eff_len    = (avg_len_q > MAX_LEN) ? MAX_LEN : avg_len_q;
    assign win_n      = CNT_W'(1) << eff_len;
    assign cfg_change = (ch_sel != ch_sel_q) || (avg_len != avg_len_q);
    assign accept     = sample_valid && (sample_ch == ch_sel) && !cfg_change;
    assign sample_ext = {{LOG2_MAX_AVG{1'b0}}, sample_data};

    always_ff @(posedge CLOCK_50) begin
        ch_sel_q  <= ch_sel_d;
        avg_len_q <= avg_len_d;
        if (reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            avg_data_q <= '0;
            ledr_q     <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            avg_data_q <= avg_data_d;
            ledr_q     <= ledr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        load_avg = 1'b0;
        case (state_q)
            ACCUM: begin
                if (cfg_change) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (accept) begin
                    acc_d = acc_q + sample_ext;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == win_n) begin
                        state_d  = DONE;
                        load_avg = 1'b1;
                    end
                end
            end
            default: begin
                // IDLE and DONE both open a fresh window on an accepted sample.
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                if (accept) begin
                    acc_d = sample_ext;
                    cnt_d = CNT_W'(1);
                    if (win_n == CNT_W'(1)) begin
                        state_d  = DONE;
                        load_avg = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
        endcase
    end

    always_comb begin
        ch_sel_d   = ch_sel;
        avg_len_d  = avg_len;
        avg_data_d = load_avg ? DATA_W'(acc_d >> eff_len) : avg_data_q;
        lit_prod   = {{(MUL_W-DATA_W){1'b0}}, avg_data_d} * MUL_W'(LED_W + 1);
        lit        = lit_prod >> DATA_W;
        ledr_d     = '0;
        for (int i = 0; i < LED_W; i++) begin
            ledr_d[i] = (MUL_W'(i) < lit);
        end
    end

    always_comb begin
        avg_valid = (state_q == DONE);
        avg_data  = avg_data_q;
        ledr_bar  = ledr_q;
    end

`ifdef PEAK_HOLD_EN
    logic [DATA_W-1:0] peak_q, peak_d;

    // A clear coinciding with a fresh average takes the average, not zero.
    always_comb begin
        peak_d = peak_q;
        if (state_q == DONE) begin
            if (peak_clr || (avg_data_q > peak_q)) begin
                peak_d = avg_data_q;
            end
        end else if (peak_clr) begin
            peak_d = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_data = peak_q;
`else
    logic unused_peak_clr;
    assign unused_peak_clr = peak_clr;
    assign peak_data       = '0;
`endif

endmodule

// File: tb/tb_adc_sample_avg.sv
// Testbench for adc_sample_avg: vector table, directed corner sequences and
// randomized traffic against a queue-based averaging model.
module tb_adc_sample_avg;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [11:0] sample_data;
    logic [2:0]  sample_ch;
    logic [2:0]  ch_sel;
    logic [2:0]  avg_len;
    logic        peak_clr;
    logic [11:0] avg_data;
    logic        avg_valid;
    logic [9:0]  ledr_bar;
    logic [11:0] peak_data;

`ifdef PEAK_HOLD_EN
    localparam bit PEAK_ON = 1'b1;
`else
    localparam bit PEAK_ON = 1'b0;
`endif

    adc_sample_avg dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ch    (sample_ch),
        .ch_sel       (ch_sel),
        .avg_len      (avg_len),
        .peak_clr     (peak_clr),
        .avg_data     (avg_data),
        .avg_valid    (avg_valid),
        .ledr_bar     (ledr_bar),
        .peak_data    (peak_data)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic        v;
        logic [11:0] d;
        logic [2:0]  ch;
        logic        expV;
        logic [11:0] expAvg;
        logic [9:0]  expLed;
    } vec_t;

    vec_t vecs[13];

    int total = 0;
    int bad = 0;
    int pulses = 0;

    // Reference model state: samples of the open window plus expected outputs.
    int win[$];
    int expV = 0;
    int expAvg = 0;
    int expLed = 0;
    int expPeak = 0;
    logic [2:0] prevSel;
    logic [2:0] prevLen;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Window rules: accepted = valid, matching channel, config unchanged;
    // a config change empties the window; the Nth sample yields the mean.
    task automatic modelStep();
        int n;
        int sum;
        int lit;
        int newV;
        bit change;
        if (reset) begin
            win.delete();
            expV = 0;
            expAvg = 0;
            expLed = 0;
            expPeak = 0;
        end else begin
            change = (ch_sel != prevSel) || (avg_len != prevLen);
            if (PEAK_ON) begin
                if (expV != 0) begin
                    expPeak = peak_clr ? expAvg : ((expAvg > expPeak) ? expAvg : expPeak);
                end else if (peak_clr) begin
                    expPeak = 0;
                end
            end
            newV = 0;
            if (change) begin
                win.delete();
            end else if (sample_valid && (sample_ch == ch_sel)) begin
                win.push_back(int'(sample_data));
                n = 1 << ((avg_len > 3'd4) ? 4 : int'(avg_len));
                if (win.size() == n) begin
                    sum = 0;
                    foreach (win[k]) sum += win[k];
                    expAvg = sum / n;
                    lit = (expAvg * 11) / 4096;
                    expLed = (1 << lit) - 1;
                    newV = 1;
                    win.delete();
                end
            end
            expV = newV;
        end
        prevSel = ch_sel;
        prevLen = avg_len;
    endtask

    task automatic checkModel();
        checkOutput("model_avg_valid", 32'(avg_valid), 32'(expV));
        checkOutput("model_avg_data", 32'(avg_data), 32'(expAvg));
        checkOutput("model_ledr_bar", 32'(ledr_bar), 32'(expLed));
        checkOutput("model_peak_data", 32'(peak_data), 32'(expPeak));
    endtask

    task automatic applyStimulus(input logic v, input logic [11:0] d, input logic [2:0] ch);
        sample_valid = v;
        sample_data = d;
        sample_ch = ch;
        @(posedge CLOCK_50);
        modelStep();
        #1;
        checkModel();
        if (avg_valid) pulses++;
        sample_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 12'd100,  3'd0, 1'b0, 12'd0,   10'd0};
        vecs[1]  = '{1'b1, 12'd200,  3'd0, 1'b0, 12'd0,   10'd0};
        vecs[2]  = '{1'b1, 12'd300,  3'd0, 1'b0, 12'd0,   10'd0};
        vecs[3]  = '{1'b1, 12'd400,  3'd0, 1'b1, 12'd250, 10'd0};
        vecs[4]  = '{1'b0, 12'd0,    3'd0, 1'b0, 12'd250, 10'd0};
        vecs[5]  = '{1'b1, 12'd100,  3'd0, 1'b0, 12'd250, 10'd0};
        vecs[6]  = '{1'b1, 12'd4095, 3'd1, 1'b0, 12'd250, 10'd0};
        vecs[7]  = '{1'b1, 12'd200,  3'd0, 1'b0, 12'd250, 10'd0};
        vecs[8]  = '{1'b1, 12'd4095, 3'd1, 1'b0, 12'd250, 10'd0};
        vecs[9]  = '{1'b1, 12'd300,  3'd0, 1'b0, 12'd250, 10'd0};
        vecs[10] = '{1'b1, 12'd4095, 3'd1, 1'b0, 12'd250, 10'd0};
        vecs[11] = '{1'b1, 12'd400,  3'd0, 1'b1, 12'd250, 10'd0};
        vecs[12] = '{1'b1, 12'd4095, 3'd1, 1'b0, 12'd250, 10'd0};

        reset = 1'b1;
        sample_valid = 1'b0;
        sample_data = '0;
        sample_ch = '0;
        ch_sel = 3'd0;
        avg_len = 3'd2;
        peak_clr = 1'b0;
        applyStimulus(1'b0, 12'd0, 3'd0);
        applyStimulus(1'b0, 12'd0, 3'd0);
        reset = 1'b0;
        checkOutput("reset_avg_valid", 32'(avg_valid), 32'd0);
        checkOutput("reset_avg_data", 32'(avg_data), 32'd0);
        checkOutput("reset_ledr_bar", 32'(ledr_bar), 32'd0);
        checkOutput("reset_peak_data", 32'(peak_data), 32'd0);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].v, vecs[i].d, vecs[i].ch);
            checkOutput($sformatf("vec%0d_valid", i), 32'(avg_valid), 32'(vecs[i].expV));
            checkOutput($sformatf("vec%0d_avg", i), 32'(avg_data), 32'(vecs[i].expAvg));
            checkOutput($sformatf("vec%0d_led", i), 32'(ledr_bar), 32'(vecs[i].expLed));
        end

        // Single-sample window and thermometer end points.
        avg_len = 3'd0;
        applyStimulus(1'b0, 12'd0, 3'd0);
        applyStimulus(1'b1, 12'hFFF, 3'd0);
        checkOutput("n1_valid", 32'(avg_valid), 32'd1);
        checkOutput("n1_avg_fff", 32'(avg_data), 32'hFFF);
        checkOutput("n1_led_full", 32'(ledr_bar), 32'h3FF);
        applyStimulus(1'b0, 12'd0, 3'd0);
        applyStimulus(1'b1, 12'h800, 3'd0);
        checkOutput("n1_avg_800", 32'(avg_data), 32'h800);
        checkOutput("n1_led_half", 32'(ledr_bar), 32'h01F);

        // Channel change mid-window aborts; the sample in the change cycle is dropped.
        avg_len = 3'd3;
        applyStimulus(1'b0, 12'd0, 3'd0);
        pulses = 0;
        applyStimulus(1'b1, 12'd500, 3'd0);
        applyStimulus(1'b1, 12'd500, 3'd0);
        ch_sel = 3'd2;
        applyStimulus(1'b1, 12'd999, 3'd2);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 12'd64, 3'd2);
        checkOutput("abort_valid", 32'(avg_valid), 32'd1);
        checkOutput("abort_avg", 32'(avg_data), 32'd64);
        applyStimulus(1'b0, 12'd0, 3'd0);
        checkOutput("abort_pulses", 32'(pulses), 32'd1);

        // Reset in the middle of a window.
        ch_sel = 3'd0;
        avg_len = 3'd2;
        applyStimulus(1'b0, 12'd0, 3'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 12'd500, 3'd0);
        reset = 1'b1;
        applyStimulus(1'b0, 12'd0, 3'd0);
        reset = 1'b0;
        checkOutput("midrst_avg_valid", 32'(avg_valid), 32'd0);
        checkOutput("midrst_avg_data", 32'(avg_data), 32'd0);
        checkOutput("midrst_ledr_bar", 32'(ledr_bar), 32'd0);
        checkOutput("midrst_peak_data", 32'(peak_data), 32'd0);
        pulses = 0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 12'd1000, 3'd0);
        applyStimulus(1'b0, 12'd0, 3'd0);
        checkOutput("midrst_avg_1000", 32'(avg_data), 32'd1000);
        checkOutput("midrst_pulses", 32'(pulses), 32'd1);

        // Peak hold sequence.
        avg_len = 3'd0;
        peak_clr = 1'b1;
        applyStimulus(1'b0, 12'd0, 3'd0);
        peak_clr = 1'b0;
        applyStimulus(1'b1, 12'h800, 3'd0);
        applyStimulus(1'b0, 12'd0, 3'd0);
        applyStimulus(1'b1, 12'h400, 3'd0);
        applyStimulus(1'b0, 12'd0, 3'd0);
        applyStimulus(1'b0, 12'd0, 3'd0);
        checkOutput("peak_max", 32'(peak_data), PEAK_ON ? 32'h800 : 32'd0);
        peak_clr = 1'b1;
        applyStimulus(1'b0, 12'd0, 3'd0);
        peak_clr = 1'b0;
        checkOutput("peak_clr", 32'(peak_data), 32'd0);
        applyStimulus(1'b1, 12'h400, 3'd0);
        applyStimulus(1'b0, 12'd0, 3'd0);
        checkOutput("peak_reload", 32'(peak_data), PEAK_ON ? 32'h400 : 32'd0);
        applyStimulus(1'b1, 12'h100, 3'd0);
        peak_clr = 1'b1;
        applyStimulus(1'b0, 12'd0, 3'd0);
        peak_clr = 1'b0;
        checkOutput("peak_clr_with_done", 32'(peak_data), PEAK_ON ? 32'h100 : 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) ch_sel = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) avg_len = 3'($urandom_range(0, 7));
            peak_clr = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 199) == 0);
            applyStimulus(($urandom_range(0, 9) < 7), 12'($urandom), 3'($urandom_range(0, 3)));
        end
        reset = 1'b0;
        peak_clr = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
